// File: rtl/encoder_8_3_seq.sv
// rtl/encoder_8_3_seq.sv - sequential 8-to-3 encoder: one index beat per set bit, lowest first
module encoder_8_3_seq #(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] s,
    output logic             out_last,
    output logic             zero_pulse,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_pulse_q, zero_pulse_d;
    logic [IDX_W-1:0]   low_idx;
    logic               one_left;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_left = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        zero_pulse_d = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        s            = '0;
        out_last     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_d = d;
                    cnt_d     = popcount(d);
                    if (d == '0) begin
                        zero_pulse_d = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                s         = low_idx;
                out_last  = one_left;
                if (out_ready) begin
                    // Clearing the lowest set bit is exactly the bit just emitted.
                    pending_d = pending_q & (pending_q - WIDTH'(1));
                    if (one_left) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            cnt_q        <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

    assign zero_pulse = zero_pulse_q;
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// tb/tb_encoder_8_3_seq.sv - scoreboard bench for encoder_8_3_seq
module tb_encoder_8_3_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] s;
    logic       out_last;
    logic       zero_pulse;
    logic [3:0] cnt;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic       ready_toggle = 1'b0;

    encoder_8_3_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .out_last   (out_last),
        .zero_pulse (zero_pulse),
        .cnt        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [2:0] idx, input logic last);
        exp_q.push_back({idx, last});
    endtask

    task automatic send(input logic [7:0] v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        d        = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d        = 8'h00;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && in_ready)}, 32'd1);
    endtask

    // out_ready driver: held high, or toggled every cycle when requested.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    // Monitor: pops expected beats on every transfer, checks stall hold and idle outputs.
    initial begin
        logic       prev_stall = 1'b0;
        logic [2:0] held_s     = 3'd0;
        logic       held_last  = 1'b0;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (prev_stall) begin
                    chk("stall_hold_s", {29'd0, s}, {29'd0, held_s});
                    chk("stall_hold_last", {31'd0, out_last}, {31'd0, held_last});
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual s=%0d last=%0b required none", s, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_s", {29'd0, s}, {29'd0, e[3:1]});
                        chk("beat_last", {31'd0, out_last}, {31'd0, e[0]});
                    end
                end
                prev_stall = !out_ready;
                held_s     = s;
                held_last  = out_last;
            end else begin
                prev_stall = 1'b0;
                if (s != 3'd0 || out_last != 1'b0) begin
                    chk("idle_s_last", {28'd0, s, out_last}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        d        = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", {29'd0, s}, 32'd0);
        chk("rst_cnt", {28'd0, cnt}, 32'd0);
        chk("rst_zero_pulse", {31'd0, zero_pulse}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single bit
        expect_beat(3'd2, 1'b1);
        send(8'b0000_0100);
        chk("t1_cnt", {28'd0, cnt}, 32'd1);
        drain("t1_drain");

        // Three bits on consecutive cycles
        expect_beat(3'd0, 1'b0);
        expect_beat(3'd3, 1'b0);
        expect_beat(3'd7, 1'b1);
        send(8'b1000_1001);
        chk("t2_cnt", {28'd0, cnt}, 32'd3);
        chk("t2_busy0", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t2_busy2", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("t2_idle3", {31'd0, in_ready}, 32'd1);
        drain("t2_drain");

        // All bits set with out_ready toggling
        for (int i = 0; i < 8; i++) expect_beat(3'(i), i == 7);
        ready_toggle = 1'b1;
        send(8'hFF);
        chk("t3_cnt", {28'd0, cnt}, 32'd8);
        drain("t3_drain");
        ready_toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // All-zero vector
        send(8'h00);
        chk("t4_zero_pulse", {31'd0, zero_pulse}, 32'd1);
        chk("t4_cnt", {28'd0, cnt}, 32'd0);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t4_pulse_gone", {31'd0, zero_pulse}, 32'd0);
        chk("t4_in_ready2", {31'd0, in_ready}, 32'd1);

        // Reset mid-vector after the first beat
        expect_beat(3'd4, 1'b0);
        send(8'hF0);
        chk("t5_cnt", {28'd0, cnt}, 32'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_s", {29'd0, s}, 32'd0);
        chk("t5_rst_cnt", {28'd0, cnt}, 32'd0);
        chk("t5_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_beats", {31'd0, out_valid}, 32'd0);

        // in_valid during EMIT is ignored
        expect_beat(3'd0, 1'b0);
        expect_beat(3'd1, 1'b1);
        send(8'h03);
        in_valid = 1'b1;
        d        = 8'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        d        = 8'h00;
        chk("t6_cnt_kept", {28'd0, cnt}, 32'd2);
        chk("t6_queue_empty", exp_q.size(), 32'd0);
        expect_beat(3'd7, 1'b1);
        send(8'h80);
        chk("t6_cnt_new", {28'd0, cnt}, 32'd1);
        drain("t6_drain");

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
